// File: rtl/risc_rf_pkg.sv
// risc_rf_pkg: shared helpers and constants for the forwarding register file
package risc_rf_pkg;
  function automatic int rf_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  localparam int R0 = 0;
endpackage

// File: rtl/risc_rf_scoreboard.sv
// risc_rf_scoreboard: per-register pending bits, set wins over a same-cycle clear
module risc_rf_scoreboard
  import risc_rf_pkg::*;
#(
  parameter int NREG = 8,
  localparam int AW = rf_aw(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_num,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_num,
  output logic [NREG-1:0] pend
);
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] r_pend;
  assign w_set = set_en ? NREG'(1) << set_num : '0;
  assign w_clr = clr_en ? NREG'(1) << clr_num : '0;
  assign pend  = r_pend;
  // clear first, then OR in the set so a newly issued op keeps its bit
  always_ff @(posedge clk)
    if (rst) r_pend <= '0;
    else     r_pend <= (r_pend & ~w_clr) | w_set;
endmodule

// File: rtl/risc_rf_fwd.sv
// risc_rf_fwd: register file with EX/WB operand forwarding and load-hazard scoreboard
module risc_rf_fwd
  import risc_rf_pkg::*;
#(
  parameter int XLEN    = 16,
  parameter int NREG    = 8,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 0,
  localparam int AW = rf_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0]   rd_num,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_hazard,
  output logic              stall,
  input  logic              ex_we,
  input  logic [AW-1:0]     ex_num,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              iss_we,
  input  logic [AW-1:0]     iss_num,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_num,
  input  logic [XLEN-1:0]   wb_data,
  output logic [31:0]       stall_cnt
);
  typedef logic [AW-1:0]   rnum_t;
  typedef logic [XLEN-1:0] word_t;
  localparam rnum_t R0N = rnum_t'(R0);
  localparam bit    ZR  = (ZERO_R0 != 0);

  word_t           r_mem [NREG];
  logic [NREG-1:0] w_pend;
  logic [31:0]     r_stall_cnt;
  logic            w_wb_ok;
  logic            w_ex_ok;
  logic            w_iss_ok;

  assign w_wb_ok  = wb_we  && !(ZR && wb_num  == R0N);
  assign w_ex_ok  = ex_we  && !(ZR && ex_num  == R0N);
  assign w_iss_ok = iss_we && !(ZR && iss_num == R0N);

  risc_rf_scoreboard #(.NREG(NREG)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (w_iss_ok),
    .set_num (iss_num),
    .clr_en  (w_wb_ok),
    .clr_num (wb_num),
    .pend    (w_pend)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rnum_t w_n;
    logic  w_z;
    logic  w_ex;
    logic  w_wb;
    assign w_n  = rd_num[k*AW +: AW];
    assign w_z  = ZR && w_n == R0N;
    assign w_ex = w_ex_ok && ex_num == w_n;
    assign w_wb = w_wb_ok && wb_num == w_n;
    assign rd_data[k*XLEN +: XLEN] = w_z ? '0 : w_ex ? ex_data : w_wb ? wb_data : r_mem[w_n];
    assign rd_hazard[k] = !w_z && w_pend[w_n] && !w_ex && !w_wb;
  end

  assign stall     = |rd_hazard;
  assign stall_cnt = r_stall_cnt;

  // architectural array: cleared on reset, written from WB
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    else if (w_wb_ok) r_mem[wb_num] <= wb_data;

  // saturating count of stalled cycles
  always_ff @(posedge clk)
    if (rst) r_stall_cnt <= '0;
    else if (stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
endmodule

// File: tb/tb_risc_rf_fwd.sv
// tb_risc_rf_fwd: directed and randomized checks of risc_rf_fwd with ZERO_R0 = 0 and 1
module tb_risc_rf_fwd;
  logic        clk = 0;
  logic        rst = 1;
  logic [5:0]  rd_num = '0;
  logic        ex_we = 0, iss_we = 0, wb_we = 0;
  logic [2:0]  ex_num = '0, iss_num = '0, wb_num = '0;
  logic [15:0] ex_data = '0, wb_data = '0;
  logic [31:0] o_data [2];
  logic [1:0]  o_haz [2];
  logic        o_stall [2];
  logic [31:0] o_cnt [2];
  logic [15:0] mem [2][8];
  bit          pend [2][8];
  logic [31:0] cnt [2];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  risc_rf_fwd #(.XLEN(16), .NREG(8), .NRD(2), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .rd_num(rd_num), .rd_data(o_data[0]), .rd_hazard(o_haz[0]),
    .stall(o_stall[0]), .ex_we(ex_we), .ex_num(ex_num), .ex_data(ex_data),
    .iss_we(iss_we), .iss_num(iss_num), .wb_we(wb_we), .wb_num(wb_num),
    .wb_data(wb_data), .stall_cnt(o_cnt[0]));

  risc_rf_fwd #(.XLEN(16), .NREG(8), .NRD(2), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .rd_num(rd_num), .rd_data(o_data[1]), .rd_hazard(o_haz[1]),
    .stall(o_stall[1]), .ex_we(ex_we), .ex_num(ex_num), .ex_data(ex_data),
    .iss_we(iss_we), .iss_num(iss_num), .wb_we(wb_we), .wb_num(wb_num),
    .wb_data(wb_data), .stall_cnt(o_cnt[1]));

  function automatic logic [15:0] exp_data(int d, logic [2:0] n);
    if (d == 1 && n == 0) return 16'h0;
    if (ex_we && ex_num == n) return ex_data;
    if (wb_we && wb_num == n) return wb_data;
    return mem[d][n];
  endfunction

  function automatic bit exp_haz(int d, logic [2:0] n);
    if (d == 1 && n == 0) return 0;
    return pend[d][n] && !(ex_we && ex_num == n) && !(wb_we && wb_num == n);
  endfunction

  task automatic idle();
    ex_we = 0; iss_we = 0; wb_we = 0;
  endtask

  task automatic tick();
    bit st [2];
    for (int d = 0; d < 2; d++) st[d] = exp_haz(d, rd_num[2:0]) || exp_haz(d, rd_num[5:3]);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int r = 0; r < 8; r++) begin mem[d][r] = '0; pend[d][r] = 0; end
        cnt[d] = '0;
      end else begin
        if (st[d] && cnt[d] != 32'hFFFF_FFFF) cnt[d] = cnt[d] + 1;
        if (wb_we && !(d == 1 && wb_num == 0)) mem[d][wb_num] = wb_data;
        if (wb_we) pend[d][wb_num] = 0;
        if (iss_we && !(d == 1 && iss_num == 0)) pend[d][iss_num] = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); tick(); tick();
    rst = 0; rd_num = {3'd5, 3'd3}; #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp += 3;
      if (o_data[d] !== 32'h0) begin n_err++; $display("FAIL reset_data d%0d got %h exp 0", d, o_data[d]); end
      if (o_stall[d] !== 1'b0) begin n_err++; $display("FAIL reset_stall d%0d got %b exp 0", d, o_stall[d]); end
      if (o_cnt[d] !== 32'h0) begin n_err++; $display("FAIL reset_cnt d%0d got %h exp 0", d, o_cnt[d]); end
    end
    tick();
  endtask

  task automatic test_wb_bypass();
    wb_we = 1; wb_num = 3; wb_data = 16'h1234; rd_num = {3'd5, 3'd3}; #1;
    n_cmp++;
    if (o_data[0][15:0] !== 16'h1234) begin n_err++; $display("FAIL wb_bypass got %h exp 1234", o_data[0][15:0]); end
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if (o_data[0][15:0] !== 16'h1234) begin n_err++; $display("FAIL wb_array c%0d got %h exp 1234", i, o_data[0][15:0]); end
      tick();
    end
  endtask

  task automatic test_ex_priority();
    ex_we = 1; ex_num = 2; ex_data = 16'hAAAA;
    wb_we = 1; wb_num = 2; wb_data = 16'h5555; rd_num = {3'd2, 3'd3}; #1;
    n_cmp++;
    if (o_data[0][31:16] !== 16'hAAAA) begin n_err++; $display("FAIL ex_prio got %h exp aaaa", o_data[0][31:16]); end
    tick(); idle(); #1;
    n_cmp++;
    if (o_data[0][31:16] !== 16'h5555) begin n_err++; $display("FAIL ex_prio_next got %h exp 5555", o_data[0][31:16]); end
    tick();
  endtask

  task automatic test_load_hazard();
    iss_we = 1; iss_num = 4; rd_num = {3'd2, 3'd4}; tick(); idle();
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp += 2;
      if (o_haz[0][0] !== 1'b1) begin n_err++; $display("FAIL load_haz c%0d got %b exp 1", i, o_haz[0][0]); end
      if (o_stall[1] !== 1'b1) begin n_err++; $display("FAIL load_stall c%0d got %b exp 1", i, o_stall[1]); end
      tick();
    end
    n_cmp += 2;
    if (o_cnt[0] !== 32'd3) begin n_err++; $display("FAIL stall_cnt got %0d exp 3", o_cnt[0]); end
    if (o_cnt[1] !== 32'd3) begin n_err++; $display("FAIL stall_cnt_z got %0d exp 3", o_cnt[1]); end
    wb_we = 1; wb_num = 4; wb_data = 16'h00FF; #1;
    n_cmp += 3;
    if (o_haz[0][0] !== 1'b0) begin n_err++; $display("FAIL load_wb_haz got %b exp 0", o_haz[0][0]); end
    if (o_stall[0] !== 1'b0) begin n_err++; $display("FAIL load_wb_stall got %b exp 0", o_stall[0]); end
    if (o_data[0][15:0] !== 16'h00FF) begin n_err++; $display("FAIL load_wb_data got %h exp 00ff", o_data[0][15:0]); end
    tick(); idle();
  endtask

  task automatic test_set_wins();
    rd_num = {3'd1, 3'd1};
    iss_we = 1; iss_num = 6; tick();
    wb_we = 1; wb_num = 6; wb_data = 16'hBEEF; tick(); idle();
    rd_num = {3'd6, 3'd6}; #1;
    n_cmp += 2;
    if (o_haz[0] !== 2'b11) begin n_err++; $display("FAIL set_wins got %b exp 11", o_haz[0]); end
    if (o_data[0][15:0] !== o_data[0][31:16] || o_data[0][15:0] !== 16'hBEEF) begin
      n_err++; $display("FAIL same_port_data got %h exp beefbeef", o_data[0]);
    end
    tick();
    wb_we = 1; wb_num = 6; wb_data = 16'h0606; tick(); idle();
  endtask

  task automatic test_zero_r0();
    rd_num = {3'd1, 3'd1};
    wb_we = 1; wb_num = 0; wb_data = 16'hFFFF; iss_we = 1; iss_num = 0; tick(); idle();
    rd_num = {3'd1, 3'd0}; #1;
    n_cmp += 3;
    if (o_data[1][15:0] !== 16'h0) begin n_err++; $display("FAIL r0_zero_data got %h exp 0", o_data[1][15:0]); end
    if (o_haz[1][0] !== 1'b0) begin n_err++; $display("FAIL r0_zero_haz got %b exp 0", o_haz[1][0]); end
    if (o_data[0][15:0] !== 16'hFFFF) begin n_err++; $display("FAIL r0_plain_data got %h exp ffff", o_data[0][15:0]); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 59) == 0);
      rd_num  = 6'($urandom);
      if ($urandom_range(0, 3) == 0) rd_num[5:3] = rd_num[2:0];
      ex_we   = ($urandom_range(0, 3) == 0);
      ex_num  = 3'($urandom); ex_data = 16'($urandom);
      iss_we  = ($urandom_range(0, 2) == 0);
      iss_num = 3'($urandom);
      wb_we   = ($urandom_range(0, 1) == 0);
      wb_num  = 3'($urandom); wb_data = 16'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        bit st = 0;
        for (int k = 0; k < 2; k++) begin
          logic [2:0]  n = rd_num[k*3 +: 3];
          logic [15:0] ed = exp_data(d, n);
          bit          eh = exp_haz(d, n);
          st |= eh;
          n_cmp += 2;
          if (o_data[d][k*16 +: 16] !== ed) begin
            n_err++; $display("FAIL rnd_data c%0d d%0d p%0d got %h exp %h", c, d, k, o_data[d][k*16 +: 16], ed);
          end
          if (o_haz[d][k] !== eh) begin
            n_err++; $display("FAIL rnd_haz c%0d d%0d p%0d got %b exp %b", c, d, k, o_haz[d][k], eh);
          end
        end
        n_cmp += 2;
        if (o_stall[d] !== st) begin n_err++; $display("FAIL rnd_stall c%0d d%0d got %b exp %b", c, d, o_stall[d], st); end
        if (o_cnt[d] !== cnt[d]) begin n_err++; $display("FAIL rnd_cnt c%0d d%0d got %0d exp %0d", c, d, o_cnt[d], cnt[d]); end
      end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cnt[d] = '0;
      for (int r = 0; r < 8; r++) begin mem[d][r] = '0; pend[d][r] = 0; end
    end
    #1;
    test_reset();
    test_wb_bypass();
    test_ex_priority();
    test_load_hazard();
    test_set_wins();
    test_zero_r0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/risc_rf_fwd.md
Name: risc_rf_fwd

Overview:
Parametrised register file for the next-generation RISC pipeline cores. It folds in the ID-stage operand forwarding that earlier cores built by hand, and adds a pending-write scoreboard so that multi-cycle results (loads on wait-stated memory) stall dependent reads instead of returning stale data. It sits between the decode stage (read ports), the EX stage (bypass and issue) and the WB stage (write port).

Parameters:
XLEN, 16, data width in bits.
NREG, 8, number of architectural registers (power of 2, at least 2).
NRD, 2, number of read ports (1..4).
ZERO_R0, 0, 1 = r0 is hardwired to zero.
AW, $clog2(NREG), register-number width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rd_num  in  NRD*AW  read register numbers, port k at [k*AW +: AW]
rd_data  out  NRD*XLEN  forwarded read data, port k at [k*XLEN +: XLEN]
rd_hazard  out  NRD  port k source is pending and not forwardable
stall  out  1  OR of rd_hazard over all ports
ex_we  in  1  EX-stage result valid this cycle
ex_num  in  AW  EX-stage destination register
ex_data  in  XLEN  EX-stage result
iss_we  in  1  long-latency op issued; mark destination pending
iss_num  in  AW  destination of long-latency op
wb_we  in  1  write-back enable
wb_num  in  AW  write-back register
wb_data  in  XLEN  write-back data
stall_cnt  out  32  saturating count of cycles with stall=1

Behaviour:
- Reset (rst=1 at posedge clk): all registers 0, scoreboard cleared, stall_cnt 0. rd_data reflects the cleared array, so it reads 0 unless bypassed. rd_hazard and stall are 0.
- Read path is combinational, zero latency. Per-port priority:
  - ex_we && ex_num==rd_num gives ex_data;
  - else wb_we && wb_num==rd_num gives wb_data;
  - else array contents.
- Write: on wb_we, array[wb_num] <= wb_data at posedge. It is visible through the array from the next cycle, and through the bypass in the same cycle.
- Scoreboard (one bit per register):
  - iss_we sets bit[iss_num].
  - wb_we clears bit[wb_num].
  - If set and clear target the same register in the same cycle, set wins (a newer op is in flight).
  - ex_we does not clear the bit.
- rd_hazard[k] = bit[rd_num_k] && !(wb_we && wb_num==rd_num_k) && !(ex_we && ex_num==rd_num_k). It is purely combinational from the current bit state and inputs.
- ZERO_R0=1, reads of r0: always return 0 and never hazard.
- ZERO_R0=1, writes to r0: wb, ex bypass and iss targeting r0 are ignored.
- ZERO_R0=0: r0 is an ordinary register.
- stall_cnt increments by 1 each cycle with stall=1 and saturates at 32'hFFFF_FFFF.
- Multiple read ports with the same number return identical data and identical hazard.
- Reset mid-operation: pending bits drop at the reset edge. The pipeline flushes on the same rst, so no hazard survives reset.
- Out-of-range register numbers cannot occur, because NREG is a power of 2.

Decomposition:
- Package risc_rf_pkg holds:
  - the localparam helper function for AW;
  - typedef rnum_t (logic [AW-1:0]) and word_t (logic [XLEN-1:0]), as parametrised typedefs via a parameterised class or per-instance localparams;
  - constant R0 = '0.
- One sub-module, risc_rf_scoreboard: NREG-bit set/clear vector with set-wins priority and a pending-query output. The forwarding mux, array and stall counter stay in the top level.

Test Plan:
- Reset then read, defaults: rd_num={3,5}, no writes -> rd_data={0,0}, stall=0, stall_cnt=0.
- WB write and bypass: wb_we=1, wb_num=3, wb_data=16'h1234 with rd_num[0]=3 -> rd_data[0]=16'h1234 the same cycle and every later cycle with wb_we=0.
- EX over WB priority: ex_we=1, ex_num=2, ex_data=16'hAAAA; wb_we=1, wb_num=2, wb_data=16'h5555; rd_num[1]=2 -> rd_data[1]=16'hAAAA. Next cycle, with no ex/wb, rd_data[1]=16'h5555.
- Load hazard: iss_we=1, iss_num=4; hold rd_num[0]=4 for 3 idle cycles -> rd_hazard[0]=1 and stall=1 for those 3 cycles, stall_cnt=3. Then wb_we=1, wb_num=4, wb_data=16'h00FF -> that cycle hazard=0 and rd_data[0]=16'h00FF.
- Set-wins collision: r6 pending; same cycle iss_we=1, iss_num=6, wb_we=1, wb_num=6 -> next cycle, reading r6 gives rd_hazard=1.
- ZERO_R0=1: wb_we=1, wb_num=0, wb_data=16'hFFFF, and iss_we=1, iss_num=0 -> reading r0 returns 0 and hazard 0. With ZERO_R0=0 the same stimulus returns 16'hFFFF after write-back.
